// File: rtl/logic_op_arbiter_if.sv
// Handshake bundle between two logic-op requesters, the shared arbiter and the result consumer.
// Carries res_zero only when LOGIC_OP_ZERO_FLAG_EN is defined.
interface logic_op_arbiter_if #(
    parameter int NR_OF_BITS = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [NR_OF_BITS-1:0] req0_a;
    logic [NR_OF_BITS-1:0] req0_b;
    logic [1:0]            req0_op;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [NR_OF_BITS-1:0] req1_a;
    logic [NR_OF_BITS-1:0] req1_b;
    logic [1:0]            req1_op;
    logic                  res_valid;
    logic                  res_ready;
    logic [NR_OF_BITS-1:0] res_data;
    logic                  res_id;
`ifdef LOGIC_OP_ZERO_FLAG_EN
    logic                  res_zero;
`endif

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data,
`ifdef LOGIC_OP_ZERO_FLAG_EN
        output res_zero,
`endif
        output res_id
    );

    // Requester / consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data,
`ifdef LOGIC_OP_ZERO_FLAG_EN
        input  res_zero,
`endif
        input  res_id
    );
endinterface

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one bitwise AND/OR/XOR/NOR unit between two requesters,
// with a single registered, tagged result slot. Optional zero flag: LOGIC_OP_ZERO_FLAG_EN.
module logic_op_arbiter #(
    parameter int NR_OF_BITS = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    logic_op_arbiter_if.slave bus
);
    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t                r_state;
    logic                  r_ptr;
    logic                  r_res_valid;
    logic [NR_OF_BITS-1:0] r_res_data;
    logic                  r_res_id;

    logic                  w_can_accept;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic [NR_OF_BITS-1:0] w_a;
    logic [NR_OF_BITS-1:0] w_b;
    logic [1:0]            w_op;
    logic [NR_OF_BITS-1:0] w_result;

    // Readies are suppressed while reset is asserted so nothing is offered as accepted.
    assign w_can_accept = reset_n & ((r_state == ST_EMPTY) | (bus.res_ready & r_res_valid));
    assign w_gnt0 = w_can_accept & bus.req0_valid & (~bus.req1_valid | ~r_ptr);
    assign w_gnt1 = w_can_accept & bus.req1_valid & (~bus.req0_valid |  r_ptr);

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;

    assign w_a  = w_gnt1 ? bus.req1_a  : bus.req0_a;
    assign w_b  = w_gnt1 ? bus.req1_b  : bus.req0_b;
    assign w_op = w_gnt1 ? bus.req1_op : bus.req0_op;

    genvar gi;
    generate
        for (gi = 0; gi < NR_OF_BITS; gi++) begin : g_bit
            assign w_result[gi] = (w_op == 2'b00) ?  (w_a[gi] & w_b[gi]) :
                                  (w_op == 2'b01) ?  (w_a[gi] | w_b[gi]) :
                                  (w_op == 2'b10) ?  (w_a[gi] ^ w_b[gi]) :
                                                    ~(w_a[gi] | w_b[gi]);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ST_EMPTY;
            r_ptr       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= 1'b0;
        end else if (w_gnt0 | w_gnt1) begin
            // Covers both the empty-slot fill and the drain-and-refill case.
            r_state     <= ST_FULL;
            r_ptr       <= ~w_gnt1 ? 1'b1 : 1'b0;
            r_res_valid <= 1'b1;
            r_res_data  <= w_result;
            r_res_id    <= w_gnt1;
        end else if (r_res_valid & bus.res_ready) begin
            r_state     <= ST_EMPTY;
            r_res_valid <= 1'b0;
        end
    end

    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_id    = r_res_id;

`ifdef LOGIC_OP_ZERO_FLAG_EN
    logic r_res_zero;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_res_zero <= 1'b0;
        end else if (w_gnt0 | w_gnt1) begin
            r_res_zero <= (w_result == '0);
        end
    end

    assign bus.res_zero = r_res_zero;
`endif
endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: directed scenarios with literal expectations plus a random
// phase, all cross-checked every cycle against a behavioural model of the result slot.
module tb_logic_op_arbiter;
    localparam int W = 32;

    logic clock;
    logic reset_n;
    int   n_compared;
    int   n_mismatched;

    logic_op_arbiter_if #(.NR_OF_BITS(W)) bus ();

    logic_op_arbiter #(.NR_OF_BITS(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Behavioural picture of the slot: is a result held, what it is, who gets priority next.
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    bit           m_id    = 1'b0;
    bit           m_zero  = 1'b0;
    bit           m_ptr   = 1'b0;

    always @(negedge clock) begin
        bit room, g0, g1, who;
        room = reset_n && (!m_valid || bus.res_ready);
        g0 = room && bus.req0_valid && (!bus.req1_valid || !m_ptr);
        g1 = room && bus.req1_valid && (!bus.req0_valid || m_ptr);
        chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
        chk("res_valid",  32'(bus.res_valid),  32'(m_valid));
        chk("res_data",   bus.res_data,        m_data);
        chk("res_id",     32'(bus.res_id),     32'(m_id));
`ifdef LOGIC_OP_ZERO_FLAG_EN
        chk("res_zero",   32'(bus.res_zero),   32'(m_zero));
`endif
        if (!reset_n) begin
            m_valid = 0; m_data = '0; m_id = 0; m_zero = 0; m_ptr = 0;
        end else if (g0 || g1) begin
            who     = g1;
            m_data  = who ? ref_op(bus.req1_op, bus.req1_a, bus.req1_b)
                          : ref_op(bus.req0_op, bus.req0_a, bus.req0_b);
            m_zero  = (m_data == '0);
            m_id    = who;
            m_valid = 1;
            m_ptr   = !who;
        end else if (m_valid && bus.res_ready) begin
            m_valid = 0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int n, input bit v, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    logic [W-1:0] exp_data [4];
    bit           exp_id   [4];

    initial begin
        bit acc0, acc1;
        n_compared   = 0;
        n_mismatched = 0;
        reset_n       = 1'b0;
        bus.res_ready = 1'b1;
        set_req(0, 1, 2'd0, 32'h1, 32'h1);
        set_req(1, 0, 2'd0, '0, '0);

        // Reset held two edges with a request pending
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
            chk("rst_valid",  32'(bus.res_valid),  32'd0);
            chk("rst_data",   bus.res_data,        32'h0);
        end

        // First grant after release goes to requester 0; single XOR
        reset_n = 1'b1;
        set_req(0, 1, 2'd2, 32'hFFFF0000, 32'h0F0F0F0F);
        set_req(1, 1, 2'd1, 32'h0, 32'h0);
        #1;
        chk("first_ready0", 32'(bus.req0_ready), 32'd1);
        chk("first_ready1", 32'(bus.req1_ready), 32'd0);
        set_req(1, 0, 2'd1, 32'h0, 32'h0);
        step();
        set_req(0, 0, 2'd0, '0, '0);
        chk("xor_valid", 32'(bus.res_valid), 32'd1);
        chk("xor_data",  bus.res_data,       32'hF0F00F0F);
        chk("xor_id",    32'(bus.res_id),    32'd0);

        // Contention from a fresh pointer: strict alternation
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        set_req(0, 1, 2'd0, 32'hFFFFFFFF, 32'h12345678);
        set_req(1, 1, 2'd3, 32'h0, 32'h0);
        exp_id   = '{0, 1, 0, 1};
        exp_data = '{32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF};
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_valid", 32'(bus.res_valid), 32'd1);
            chk("rr_id",    32'(bus.res_id),    32'(exp_id[k]));
            chk("rr_data",  bus.res_data,       exp_data[k]);
        end

        // Back-pressure: hold 0xA5 from requester 1 for three cycles
        set_req(0, 0, 2'd0, '0, '0);
        set_req(1, 1, 2'd1, 32'hA0, 32'h05);
        step();
        set_req(1, 0, 2'd0, '0, '0);
        set_req(0, 1, 2'd1, 32'h00FF0000, 32'h0000FF00);
        bus.res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
            step();
            chk("bp_data",  bus.res_data,       32'h000000A5);
            chk("bp_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_id",    32'(bus.res_id),    32'd1);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("refill_ready0", 32'(bus.req0_ready), 32'd1);
        step();
        set_req(0, 0, 2'd0, '0, '0);
        chk("refill_data", bus.res_data,       32'h00FFFF00);
        chk("refill_id",   32'(bus.res_id),    32'd0);

        // Reset while FULL and stalled discards the result and restores the pointer
        bus.res_ready = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_data",  bus.res_data,       32'h0);
        bus.res_ready = 1'b1;
        set_req(0, 1, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF);
        set_req(1, 1, 2'd0, 32'h1, 32'h1);
        #1;
        chk("mid_rst_ptr0", 32'(bus.req0_ready), 32'd1);
        chk("mid_rst_ptr1", 32'(bus.req1_ready), 32'd0);

        // XOR of equal words gives zero, then requester 1's AND 1&1 is nonzero
        step();
        chk("eq_data", bus.res_data, 32'h0);
`ifdef LOGIC_OP_ZERO_FLAG_EN
        chk("eq_zero", 32'(bus.res_zero), 32'd1);
`endif
        set_req(0, 0, 2'd0, '0, '0);
        step();
        set_req(1, 0, 2'd0, '0, '0);
        chk("and_data", bus.res_data, 32'h1);
`ifdef LOGIC_OP_ZERO_FLAG_EN
        chk("and_zero", 32'(bus.res_zero), 32'd0);
`endif

        // Random traffic: requests held until accepted, random consumer stalls, rare resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;
            @(posedge clock);
            #1;
            reset_n = ($urandom_range(0, 199) != 0);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            if (acc0 || !bus.req0_valid)
                set_req(0, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                        ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom(), $urandom());
            if (acc1 || !bus.req1_valid)
                set_req(1, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                        ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom(), $urandom());
        end
        reset_n = 1'b1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
